vga_timing_monitor: RTL and testbench

Passive receiver for the VGA output of the elevator display path. It samples hsync, vsync and the 12-bit RGB bus on the pixel clock and locks onto 640x480@60 timing. It reports the current pixel coordinate, flags horizontal and vertical timing violations, and captures the colour at one programmable probe pixel. It is used on-chip for display self-test and in the bench as the checker at the far end of the VGA pins.

---
 rtl/vga_timing_monitor.sv | 246 ++++++++++++++++++++++++
 tb/tb_vga_timing_monitor.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_monitor.sv
// vga_timing_monitor
// Passive checker for a VGA pin stream. It locks onto the configured timing,
// reports the coordinate of each visible sample, flags sync timing errors and
// captures the colour of one probe pixel.
module vga_timing_monitor #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int PROBE_X  = 320,
    parameter int PROBE_Y  = 240
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [3:0]  R,
    input  logic [3:0]  G,
    input  logic [3:0]  B,
    input  logic        clr_err,
    output logic        locked,
    output logic        de,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        h_err,
    output logic        v_err,
    output logic [11:0] probe_rgb,
    output logic        probe_valid,
    output logic [7:0]  frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // The counter value seen at a sync edge is the index of the last sample
    // of the previous period, hence the "- 1".
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_W = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_W = 10'(V_SYNC);
    localparam logic [9:0] H_VIS_LO = 10'(H_SYNC + H_BP);
    localparam logic [9:0] H_VIS_HI = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [9:0] V_VIS_LO = 10'(V_SYNC + V_BP);
    localparam logic [9:0] V_VIS_HI = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
    localparam logic [9:0] PROBE_XW = 10'(PROBE_X);
    localparam logic [9:0] PROBE_YW = 10'(PROBE_Y);
    localparam logic [9:0] CNT_MAX  = 10'd1023;

    typedef enum logic [1:0] {
        SEARCH,
        CHECK,
        LOCKED
    } state_t;

    state_t state;
    state_t next_state;

    logic        hs_q;
    logic        vs_q;
    logic        hs_d;
    logic [11:0] rgb_q;

    logic [9:0]  h_cnt;
    logic [9:0]  hs_low;
    logic [9:0]  hs_width;
    logic [9:0]  v_cnt;
    logic [9:0]  vs_low;
    logic        vs_line;

    logic        h_fall;
    logic        h_rise;
    logic        v_start;
    logic        h_viol;
    logic        v_viol;
    logic [9:0]  h_next;
    logic [9:0]  v_next;
    logic        vis_next;
    logic [9:0]  x_next;
    logic [9:0]  y_next;
    logic        probe_hit;

    // Register the pins once; everything downstream works on these copies.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            hs_q  <= 1'b0;
            vs_q  <= 1'b0;
            hs_d  <= 1'b0;
            rgb_q <= '0;
        end else begin
            hs_q  <= hsync;
            vs_q  <= vsync;
            hs_d  <= hs_q;
            rgb_q <= {R, G, B};
        end
    end

    // Edge detection, coordinate of the current sample and violation checks.
    // The coordinate is computed combinationally so the registered outputs
    // appear two cycles after the pin sample.
    always_comb begin
        h_fall  = hs_d & ~hs_q;
        h_rise  = ~hs_d & hs_q;
        v_start = h_fall & ~vs_q & vs_line;

        if (h_fall) begin
            h_next = '0;
        end else if (h_cnt == CNT_MAX) begin
            h_next = h_cnt;
        end else begin
            h_next = h_cnt + 10'd1;
        end

        v_next = v_cnt;
        if (v_start) begin
            v_next = '0;
        end else if (h_fall && (v_cnt != CNT_MAX)) begin
            v_next = v_cnt + 10'd1;
        end

        h_viol = (state != SEARCH) && h_fall &&
                 ((h_cnt != H_LAST) || (hs_width != H_SYNC_W));
        v_viol = (state != SEARCH) && v_start &&
                 ((v_cnt != V_LAST) || (vs_low != V_SYNC_W));
    end

    // Line/frame counters and sync pulse width measurement.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            h_cnt    <= '0;
            hs_low   <= '0;
            hs_width <= '0;
            v_cnt    <= '0;
            vs_low   <= '0;
            vs_line  <= 1'b0;
        end else begin
            h_cnt <= h_next;
            v_cnt <= v_next;
            if (!hs_q) begin
                if (h_fall) begin
                    hs_low <= 10'd1;
                end else if (hs_low != CNT_MAX) begin
                    hs_low <= hs_low + 10'd1;
                end
            end
            if (h_rise) begin
                hs_width <= hs_low;
            end
            if (h_fall) begin
                vs_line <= vs_q;
                if (!vs_q) begin
                    if (v_start) begin
                        vs_low <= 10'd1;
                    end else if (vs_low != CNT_MAX) begin
                        vs_low <= vs_low + 10'd1;
                    end
                end
            end
        end
    end

    // Lock state register.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state <= SEARCH;
        end else begin
            state <= next_state;
        end
    end

    // Lock sequencing: one clean frame between two vsync starts earns lock.
    always_comb begin
        next_state = state;
        case (state)
            SEARCH: begin
                if (v_start) begin
                    next_state = CHECK;
                end
            end
            CHECK: begin
                if (h_viol || v_viol) begin
                    next_state = SEARCH;
                end else if (v_start) begin
                    next_state = LOCKED;
                end
            end
            LOCKED: begin
                if (h_viol || v_viol) begin
                    next_state = SEARCH;
                end
            end
            default: next_state = SEARCH;
        endcase
    end

    assign locked = (state == LOCKED);

    // Visible-region decode, using the next state so de drops on the same
    // edge that breaks lock.
    always_comb begin
        vis_next = (next_state == LOCKED) &&
                   (h_next >= H_VIS_LO) && (h_next <= H_VIS_HI) &&
                   (v_next >= V_VIS_LO) && (v_next <= V_VIS_HI);
        x_next    = vis_next ? (h_next - H_VIS_LO) : '0;
        y_next    = vis_next ? (v_next - V_VIS_LO) : '0;
        probe_hit = vis_next && (x_next == PROBE_XW) && (y_next == PROBE_YW);
    end

    // Registered pixel outputs and probe capture.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            probe_rgb   <= '0;
            probe_valid <= 1'b0;
        end else begin
            de          <= vis_next;
            x           <= x_next;
            y           <= y_next;
            probe_valid <= probe_hit;
            if (probe_hit) begin
                probe_rgb <= rgb_q;
            end
        end
    end

    // Sticky error flags (a new violation wins over clr_err) and frame count.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            h_err       <= 1'b0;
            v_err       <= 1'b0;
            frame_count <= '0;
        end else begin
            h_err <= h_viol | (h_err & ~clr_err);
            v_err <= v_viol | (v_err & ~clr_err);
            if (v_start && (state == LOCKED)) begin
                frame_count <= frame_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_monitor.sv
// tb_vga_timing_monitor
// Directed bench for vga_timing_monitor using a shrunken 16x8 timing so many
// frames fit in a short run.
module tb_vga_timing_monitor;

    localparam int H_ACTIVE = 8;
    localparam int H_FP     = 2;
    localparam int H_SYNC   = 3;
    localparam int H_BP     = 3;
    localparam int V_ACTIVE = 4;
    localparam int V_FP     = 1;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 1;
    localparam int PROBE_X  = 5;
    localparam int PROBE_Y  = 2;
    localparam int H_LEN    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_LEN    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_LO     = H_SYNC + H_BP;
    localparam int V_LO     = V_SYNC + V_BP;

    logic        clk = 1'b0;
    logic        nRst;
    logic        hsync;
    logic        vsync;
    logic [3:0]  R;
    logic [3:0]  G;
    logic [3:0]  B;
    logic        clr_err;
    logic        locked;
    logic        de;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        h_err;
    logic        v_err;
    logic [11:0] probe_rgb;
    logic        probe_valid;
    logic [7:0]  frame_count;

    int n_cmp   = 0;
    int n_bad   = 0;
    int px_bad  = 0;
    int de_seen = 0;
    int pv_seen = 0;

    logic       p_de = 1'b0;
    logic [9:0] p_x  = '0;
    logic [9:0] p_y  = '0;
    logic       p_pv = 1'b0;

    logic lk_a [V_LEN];
    logic lk_b [V_LEN];
    logic he_a [V_LEN];
    logic he_b [V_LEN];

    logic        rs_locked;
    logic        rs_de;
    logic [9:0]  rs_x;
    logic [11:0] rs_rgb;
    logic [7:0]  rs_fc;

    vga_timing_monitor #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .PROBE_X(PROBE_X), .PROBE_Y(PROBE_Y)
    ) dut (
        .clk(clk),
        .nRst(nRst),
        .hsync(hsync),
        .vsync(vsync),
        .R(R),
        .G(G),
        .B(B),
        .clr_err(clr_err),
        .locked(locked),
        .de(de),
        .x(x),
        .y(y),
        .h_err(h_err),
        .v_err(v_err),
        .probe_rgb(probe_rgb),
        .probe_valid(probe_valid),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Drive one pin sample, then compare the outputs (which belong to the
    // previous sample) against the expectation queued one step earlier.
    task automatic applyStimulus(input logic hs, input logic vs, input logic [11:0] rgb,
                                 input logic e_de, input logic [9:0] ex, input logic [9:0] ey);
        hsync     = hs;
        vsync     = vs;
        {R, G, B} = rgb;
        @(posedge clk);
        #1;
        if (de !== p_de || x !== p_x || y !== p_y || probe_valid !== p_pv) begin
            px_bad++;
        end
        de_seen += int'(de);
        pv_seen += int'(probe_valid);
        p_de = e_de;
        p_x  = ex;
        p_y  = ey;
        p_pv = e_de && (ex == 10'(PROBE_X)) && (ey == 10'(PROBE_Y));
    endtask

    // One frame of pins. short_line shortens that line by one cycle,
    // vs_lines sets the vsync low width, lock_exp is the expected lock state
    // after this frame's start, clr_line pulses clr_err, rst_line pulses nRst.
    task automatic drive_frame(input int short_line, input int vs_lines, input bit lock_exp,
                               input int clr_line, input int rst_line);
        bit         cur_lock;
        bit         geo;
        bit         vis;
        int         len;
        logic [9:0] gx;
        logic [9:0] gy;
        logic [11:0] rgb;
        cur_lock = lock_exp;
        de_seen  = 0;
        pv_seen  = 0;
        for (int l = 0; l < V_LEN; l++) begin
            len = (l == short_line) ? H_LEN - 1 : H_LEN;
            for (int hp = 0; hp < len; hp++) begin
                if (short_line >= 0 && l == short_line + 1 && hp == 0) begin
                    cur_lock = 1'b0;
                end
                gx  = 10'(hp - H_LO);
                gy  = 10'(l - V_LO);
                geo = (hp >= H_LO) && (hp < H_LO + H_ACTIVE) && (l >= V_LO) && (l < V_LO + V_ACTIVE);
                vis = cur_lock && geo;
                rgb = geo ? {gx[3:0], gy[3:0], 4'hA} : 12'h000;
                clr_err = (l == clr_line && hp == 8);
                applyStimulus(hp >= H_SYNC, l >= vs_lines, rgb, vis,
                              vis ? gx : 10'd0, vis ? gy : 10'd0);
                clr_err = 1'b0;
                if (hp == 0) begin
                    lk_a[l] = locked;
                    he_a[l] = h_err;
                end
                if (hp == 1) begin
                    lk_b[l] = locked;
                    he_b[l] = h_err;
                end
                if (l == rst_line && hp == 8) begin
                    nRst = 1'b0;
                    #2;
                    rs_locked = locked;
                    rs_de     = de;
                    rs_x      = x;
                    rs_rgb    = probe_rgb;
                    rs_fc     = frame_count;
                    nRst      = 1'b1;
                    cur_lock  = 1'b0;
                    p_de      = 1'b0;
                    p_x       = '0;
                    p_y       = '0;
                    p_pv      = 1'b0;
                end
            end
        end
    endtask

    initial begin
        nRst    = 1'b1;
        hsync   = 1'b1;
        vsync   = 1'b1;
        R       = '0;
        G       = '0;
        B       = '0;
        clr_err = 1'b0;
        #1 nRst = 1'b0;
        #2;
        checkOutput("rst_locked", locked, 0);
        checkOutput("rst_de", de, 0);
        checkOutput("rst_x", x, 0);
        checkOutput("rst_y", y, 0);
        checkOutput("rst_h_err", h_err, 0);
        checkOutput("rst_v_err", v_err, 0);
        checkOutput("rst_probe_rgb", probe_rgb, 0);
        checkOutput("rst_probe_valid", probe_valid, 0);
        checkOutput("rst_frame_count", frame_count, 0);
        repeat (3) @(posedge clk);
        #1 nRst = 1'b1;
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b1, 12'h000, 1'b0, 10'd0, 10'd0);

        // Nominal lock-up: third vsync start locks
        drive_frame(-1, 2, 1'b0, -1, -1);
        drive_frame(-1, 2, 1'b0, -1, -1);
        checkOutput("pre_lock", locked, 0);
        drive_frame(-1, 2, 1'b1, -1, -1);
        checkOutput("lock_edge_t1", lk_a[0], 0);
        checkOutput("lock_edge_t2", lk_b[0], 1);
        checkOutput("nom_de_count", de_seen, H_ACTIVE * V_ACTIVE);
        checkOutput("nom_probe_pulses", pv_seen, 1);
        checkOutput("nom_probe_rgb", probe_rgb, 12'h52A);
        checkOutput("nom_fc0", frame_count, 0);
        drive_frame(-1, 2, 1'b1, -1, -1);
        checkOutput("nom_fc1", frame_count, 1);
        checkOutput("nom_h_err", h_err, 0);
        checkOutput("nom_v_err", v_err, 0);

        // Short line 4
        drive_frame(4, 2, 1'b1, -1, -1);
        checkOutput("short_lock_t1", lk_a[5], 1);
        checkOutput("short_lock_t2", lk_b[5], 0);
        checkOutput("short_herr_t1", he_a[5], 0);
        checkOutput("short_herr_t2", he_b[5], 1);
        checkOutput("short_de_count", de_seen, 2 * H_ACTIVE);
        checkOutput("short_v_err", v_err, 0);
        drive_frame(-1, 2, 1'b0, -1, -1);
        checkOutput("short_relock_wait", locked, 0);
        drive_frame(-1, 2, 1'b1, -1, -1);
        checkOutput("short_relock", lk_b[0], 1);
        checkOutput("short_herr_sticky", h_err, 1);
        drive_frame(-1, 2, 1'b1, 5, -1);
        checkOutput("short_herr_clr", h_err, 0);
        checkOutput("short_locked_after_clr", locked, 1);

        // vsync low for 3 lines
        drive_frame(-1, 3, 1'b1, -1, -1);
        drive_frame(-1, 2, 1'b0, -1, -1);
        checkOutput("vbad_lock_t1", lk_a[0], 1);
        checkOutput("vbad_lock_t2", lk_b[0], 0);
        checkOutput("vbad_v_err", v_err, 1);
        checkOutput("vbad_h_err", h_err, 0);
        drive_frame(-1, 2, 1'b0, -1, -1);
        drive_frame(-1, 2, 1'b1, 5, -1);
        checkOutput("vbad_v_err_clr", v_err, 0);
        checkOutput("vbad_relock", locked, 1);

        // Reset mid-frame
        drive_frame(-1, 2, 1'b1, -1, 4);
        checkOutput("mrst_locked", rs_locked, 0);
        checkOutput("mrst_de", rs_de, 0);
        checkOutput("mrst_x", rs_x, 0);
        checkOutput("mrst_probe_rgb", rs_rgb, 0);
        checkOutput("mrst_frame_count", rs_fc, 0);
        drive_frame(-1, 2, 1'b0, -1, -1);
        checkOutput("mrst_check_lock_t2", lk_b[0], 0);
        checkOutput("mrst_check_locked", locked, 0);
        drive_frame(-1, 2, 1'b1, -1, -1);
        checkOutput("mrst_relock", lk_b[0], 1);
        checkOutput("mrst_fc", frame_count, 0);
        checkOutput("mrst_probe_rgb2", probe_rgb, 12'h52A);
        checkOutput("mrst_probe_pulses", pv_seen, 1);

        // frame_count wrap
        for (int f = 0; f < 255; f++) drive_frame(-1, 2, 1'b1, -1, -1);
        checkOutput("wrap_fc255", frame_count, 255);
        drive_frame(-1, 2, 1'b1, -1, -1);
        checkOutput("wrap_fc0", frame_count, 0);
        checkOutput("wrap_locked", locked, 1);

        checkOutput("pixel_stream_errors", px_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
